// File: rtl/if_stage_pipe_if.sv
// Instruction-memory bus between the fetch stage (master) and the
// instruction memory (slave). The read is combinational: imem_rdata
// reflects imem_addr in the same cycle.
interface if_stage_pipe_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int INSN_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0] imem_addr;
   logic [INSN_WIDTH-1:0] imem_rdata;

   modport master (output imem_addr, input imem_rdata);
   modport slave  (input imem_addr, output imem_rdata);
endinterface

// File: rtl/if_stage_pipe.sv
// Instruction-fetch stage with integrated IF/ID pipeline register.
// Owns the PC, drives the instruction-memory address, and latches the
// fetched word with its PC and PC+PC_STEP. Handles hold / redirect /
// flush / stall with a fixed per-edge priority, and buffers a redirect
// that arrives while the stage is held so it is applied on release.
// Optional build macro IF_STAGE_PERF_COUNT_EN adds saturating stall and
// bubble counters; without it both counter outputs are tied to zero.
module if_stage_pipe #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    INSN_WIDTH = 32,
   parameter int                    PC_STEP    = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
   parameter logic [INSN_WIDTH-1:0] NOP_INSN   = '0
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  PCSrc,
   input  logic [ADDR_WIDTH-1:0] PC_branch,
   input  logic                  stall,
   input  logic                  flush,
   input  logic                  hold,
   if_stage_pipe_if.master       imem,
   output logic [ADDR_WIDTH-1:0] PC_plus_four_out,
   output logic [INSN_WIDTH-1:0] instruction_out,
   output logic [ADDR_WIDTH-1:0] pc_out,
   output logic                  valid_out,
   output logic [15:0]           stall_cycles,
   output logic [15:0]           flush_count
);

   typedef enum logic {IDLE, PENDING} pend_state_e;

   pend_state_e           state_q, state_d;
   logic [ADDR_WIDTH-1:0] pend_target_q, pend_target_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [ADDR_WIDTH-1:0] ifid_pc_q, ifid_pc_d;
   logic [ADDR_WIDTH-1:0] ifid_ppf_q, ifid_ppf_d;
   logic [INSN_WIDTH-1:0] ifid_insn_q, ifid_insn_d;
   logic                  ifid_vld_q, ifid_vld_d;
   logic [ADDR_WIDTH-1:0] pc_next_seq;
   logic                  pend_valid;

   assign pend_valid  = (state_q == PENDING);
   // Sequential successor; wraps silently modulo 2^ADDR_WIDTH.
   assign pc_next_seq = pc_q + ADDR_WIDTH'(PC_STEP);
   assign imem.imem_addr = pc_q;

   // State registers: PC, pending-redirect machine and IF/ID entry.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         pend_target_q <= '0;
         pc_q          <= RESET_PC;
         ifid_pc_q     <= '0;
         ifid_ppf_q    <= '0;
         ifid_insn_q   <= NOP_INSN;
         ifid_vld_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         pend_target_q <= pend_target_d;
         pc_q          <= pc_d;
         ifid_pc_q     <= ifid_pc_d;
         ifid_ppf_q    <= ifid_ppf_d;
         ifid_insn_q   <= ifid_insn_d;
         ifid_vld_q    <= ifid_vld_d;
      end
   end

   // Next-state: hold > live redirect > pending redirect > flush > stall > fetch.
   always_comb begin
      state_d       = state_q;
      pend_target_d = pend_target_q;
      pc_d          = pc_q;
      ifid_pc_d     = ifid_pc_q;
      ifid_ppf_d    = ifid_ppf_q;
      ifid_insn_d   = ifid_insn_q;
      ifid_vld_d    = ifid_vld_q;
      if (hold) begin
         // Frozen; only remember the most recent redirect seen.
         if (PCSrc) begin
            state_d       = PENDING;
            pend_target_d = PC_branch;
         end
      end else if (PCSrc || pend_valid) begin
         // A live redirect is newer than any buffered one, so it wins.
         pc_d        = PCSrc ? PC_branch : pend_target_q;
         state_d     = IDLE;
         ifid_pc_d   = '0;
         ifid_ppf_d  = '0;
         ifid_insn_d = NOP_INSN;
         ifid_vld_d  = 1'b0;
      end else if (flush) begin
         pc_d        = stall ? pc_q : pc_next_seq;
         ifid_pc_d   = '0;
         ifid_ppf_d  = '0;
         ifid_insn_d = NOP_INSN;
         ifid_vld_d  = 1'b0;
      end else if (!stall) begin
         pc_d        = pc_next_seq;
         ifid_pc_d   = pc_q;
         ifid_ppf_d  = pc_next_seq;
         ifid_insn_d = imem.imem_rdata;
         ifid_vld_d  = 1'b1;
      end
   end

   assign pc_out           = ifid_pc_q;
   assign PC_plus_four_out = ifid_ppf_q;
   assign instruction_out  = ifid_insn_q;
   assign valid_out        = ifid_vld_q;

`ifdef IF_STAGE_PERF_COUNT_EN
   logic        stall_evt, bubble_evt;
   logic [15:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

   assign stall_evt  = !hold && !PCSrc && !pend_valid && !flush && stall;
   assign bubble_evt = !hold && (PCSrc || pend_valid || flush);

   // Counter registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // Saturating increments on pure-stall edges and bubble-writing edges.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall_evt && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
      if (bubble_evt && flush_cnt_q != 16'hFFFF) flush_cnt_d = flush_cnt_q + 16'd1;
   end

   assign stall_cycles = stall_cnt_q;
   assign flush_count  = flush_cnt_q;
`else
   assign stall_cycles = 16'h0;
   assign flush_count  = 16'h0;
`endif

endmodule

// File: tb/tb_if_stage_pipe.sv
// Directed bench for if_stage_pipe: a 32-bit instance for fetch, stall,
// branch, hold and flush scenarios, and an 8-bit instance with
// RESET_PC=F8 for PC wrap and asynchronous reset while a redirect is pending.
module tb_if_stage_pipe;

   logic clock;
   int   total = 0;
   int   bad   = 0;

   // 32-bit instance
   logic        reset_n, PCSrc, stall, flush, hold;
   logic [31:0] PC_branch;
   logic [31:0] ppf, insn, pco;
   logic        vld;
   logic [15:0] stall_cycles, flush_count;
   if_stage_pipe_if #(.ADDR_WIDTH(32), .INSN_WIDTH(32)) bus ();
   assign bus.imem_rdata = bus.imem_addr ^ 32'hA5A5_0000;

   if_stage_pipe dut (
      .clock(clock), .reset_n(reset_n), .PCSrc(PCSrc), .PC_branch(PC_branch),
      .stall(stall), .flush(flush), .hold(hold), .imem(bus),
      .PC_plus_four_out(ppf), .instruction_out(insn), .pc_out(pco),
      .valid_out(vld), .stall_cycles(stall_cycles), .flush_count(flush_count));

   // 8-bit instance
   logic        rst8_n, PCSrc8, stall8, flush8, hold8;
   logic [7:0]  br8, ppf8, pco8;
   logic [31:0] insn8;
   logic        vld8;
   logic [15:0] sc8, fc8;
   if_stage_pipe_if #(.ADDR_WIDTH(8), .INSN_WIDTH(32)) bus8 ();
   assign bus8.imem_rdata = {24'h0, bus8.imem_addr} ^ 32'hA5A5_0000;

   if_stage_pipe #(.ADDR_WIDTH(8), .RESET_PC(8'hF8)) dut8 (
      .clock(clock), .reset_n(rst8_n), .PCSrc(PCSrc8), .PC_branch(br8),
      .stall(stall8), .flush(flush8), .hold(hold8), .imem(bus8),
      .PC_plus_four_out(ppf8), .instruction_out(insn8), .pc_out(pco8),
      .valid_out(vld8), .stall_cycles(sc8), .flush_count(fc8));

   // Snapshots: {imem_addr, pc_out, PC_plus_four_out, instruction_out, valid_out}
   logic [128:0] snap;
   logic [56:0]  snap8;
   assign snap  = {bus.imem_addr, pco, ppf, insn, vld};
   assign snap8 = {bus8.imem_addr, pco8, ppf8, insn8, vld8};

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 0; PCSrc = 0; stall = 0; flush = 0; hold = 0; PC_branch = '0;
      rst8_n = 0; PCSrc8 = 0; stall8 = 0; flush8 = 0; hold8 = 0; br8 = '0;
      tick(); tick();
      total++;
      if (snap !== {32'h0, 32'h0, 32'h0, 32'h0, 1'b0}) begin
         bad++; $display("FAIL reset32: got %h exp %h", snap, {32'h0, 32'h0, 32'h0, 32'h0, 1'b0});
      end
      total++;
      if ({stall_cycles, flush_count} !== 32'h0) begin
         bad++; $display("FAIL reset_cnt: got %h exp 0", {stall_cycles, flush_count});
      end
      total++;
      if (snap8 !== {8'hF8, 8'h0, 8'h0, 32'h0, 1'b0}) begin
         bad++; $display("FAIL reset8: got %h exp %h", snap8, {8'hF8, 8'h0, 8'h0, 32'h0, 1'b0});
      end
      reset_n = 1;
   endtask

   task automatic test_seq_fetch();
      tick();
      total++;
      if (snap !== {32'h4, 32'h0, 32'h4, 32'hA5A5_0000, 1'b1}) begin
         bad++; $display("FAIL seq0: got %h exp %h", snap, {32'h4, 32'h0, 32'h4, 32'hA5A5_0000, 1'b1});
      end
      tick();
      total++;
      if (snap !== {32'h8, 32'h4, 32'h8, 32'hA5A5_0004, 1'b1}) begin
         bad++; $display("FAIL seq4: got %h exp %h", snap, {32'h8, 32'h4, 32'h8, 32'hA5A5_0004, 1'b1});
      end
   endtask

   task automatic test_stall();
      stall = 1;
      for (int i = 0; i < 2; i++) begin
         tick();
         total++;
         if (snap !== {32'h8, 32'h4, 32'h8, 32'hA5A5_0004, 1'b1}) begin
            bad++; $display("FAIL stall_hold%0d: got %h exp %h", i, snap, {32'h8, 32'h4, 32'h8, 32'hA5A5_0004, 1'b1});
         end
      end
      stall = 0;
      tick();
      total++;
      if (snap !== {32'hC, 32'h8, 32'hC, 32'hA5A5_0008, 1'b1}) begin
         bad++; $display("FAIL stall_release: got %h exp %h", snap, {32'hC, 32'h8, 32'hC, 32'hA5A5_0008, 1'b1});
      end
`ifdef IF_STAGE_PERF_COUNT_EN
      total++;
      if (stall_cycles !== 16'd2) begin
         bad++; $display("FAIL stall_cnt: got %0d exp 2", stall_cycles);
      end
`endif
   endtask

   task automatic test_branch_beats_stall();
      PCSrc = 1; PC_branch = 32'h40; stall = 1;
      tick();
      total++;
      if (snap !== {32'h40, 32'h0, 32'h0, 32'h0, 1'b0}) begin
         bad++; $display("FAIL branch_bubble: got %h exp %h", snap, {32'h40, 32'h0, 32'h0, 32'h0, 1'b0});
      end
      PCSrc = 0; stall = 0;
      tick();
      total++;
      if (snap !== {32'h44, 32'h40, 32'h44, 32'hA5A5_0040, 1'b1}) begin
         bad++; $display("FAIL branch_fetch: got %h exp %h", snap, {32'h44, 32'h40, 32'h44, 32'hA5A5_0040, 1'b1});
      end
   endtask

   task automatic test_hold_redirect();
      logic [31:0] tgt [3];
      logic        src [3];
      tgt = '{32'h80, 32'h90, 32'h0};
      src = '{1'b1, 1'b1, 1'b0};
      hold = 1;
      for (int i = 0; i < 3; i++) begin
         PCSrc = src[i]; PC_branch = tgt[i];
         tick();
         total++;
         if (snap !== {32'h44, 32'h40, 32'h44, 32'hA5A5_0040, 1'b1}) begin
            bad++; $display("FAIL hold_frozen%0d: got %h exp %h", i, snap, {32'h44, 32'h40, 32'h44, 32'hA5A5_0040, 1'b1});
         end
      end
      PCSrc = 0; hold = 0;
      tick();
      total++;
      if (snap !== {32'h90, 32'h0, 32'h0, 32'h0, 1'b0}) begin
         bad++; $display("FAIL hold_pending_apply: got %h exp %h", snap, {32'h90, 32'h0, 32'h0, 32'h0, 1'b0});
      end
      tick();
      total++;
      if (snap !== {32'h94, 32'h90, 32'h94, 32'hA5A5_0090, 1'b1}) begin
         bad++; $display("FAIL hold_after: got %h exp %h", snap, {32'h94, 32'h90, 32'h94, 32'hA5A5_0090, 1'b1});
      end
   endtask

   task automatic test_flush();
      // Redirect to C, fetch C so IF/ID holds a real entry, then flush at PC=10.
      PCSrc = 1; PC_branch = 32'hC;
      tick();
      PCSrc = 0;
      tick();
      total++;
      if (snap !== {32'h10, 32'hC, 32'h10, 32'hA5A5_000C, 1'b1}) begin
         bad++; $display("FAIL flush_setup: got %h exp %h", snap, {32'h10, 32'hC, 32'h10, 32'hA5A5_000C, 1'b1});
      end
      flush = 1;
      tick();
      total++;
      if (snap !== {32'h14, 32'h0, 32'h0, 32'h0, 1'b0}) begin
         bad++; $display("FAIL flush_nostall: got %h exp %h", snap, {32'h14, 32'h0, 32'h0, 32'h0, 1'b0});
      end
      flush = 0; PCSrc = 1; PC_branch = 32'hC;
      tick();
      PCSrc = 0;
      tick();
      flush = 1; stall = 1;
      tick();
      total++;
      if (snap !== {32'h10, 32'h0, 32'h0, 32'h0, 1'b0}) begin
         bad++; $display("FAIL flush_stall: got %h exp %h", snap, {32'h10, 32'h0, 32'h0, 32'h0, 1'b0});
      end
      flush = 0; stall = 0;
      tick();
      total++;
      if (snap !== {32'h14, 32'h10, 32'h14, 32'hA5A5_0010, 1'b1}) begin
         bad++; $display("FAIL flush_resume: got %h exp %h", snap, {32'h14, 32'h10, 32'h14, 32'hA5A5_0010, 1'b1});
      end
`ifdef IF_STAGE_PERF_COUNT_EN
      total++;
      if ({stall_cycles, flush_count} !== {16'd2, 16'd6}) begin
         bad++; $display("FAIL counters: got %h exp %h", {stall_cycles, flush_count}, {16'd2, 16'd6});
      end
`else
      total++;
      if ({stall_cycles, flush_count} !== 32'h0) begin
         bad++; $display("FAIL counters_off: got %h exp 0", {stall_cycles, flush_count});
      end
`endif
   endtask

   task automatic test_wrap_async_reset();
      logic [56:0] exp8 [3];
      exp8 = '{{8'hFC, 8'hF8, 8'hFC, 32'hA5A5_00F8, 1'b1},
               {8'h00, 8'hFC, 8'h00, 32'hA5A5_00FC, 1'b1},
               {8'h04, 8'h00, 8'h04, 32'hA5A5_0000, 1'b1}};
      rst8_n = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++;
         if (snap8 !== exp8[i]) begin
            bad++; $display("FAIL wrap%0d: got %h exp %h", i, snap8, exp8[i]);
         end
      end
      hold8 = 1; PCSrc8 = 1; br8 = 8'h30;
      tick();
      PCSrc8 = 0;
      total++;
      if (snap8 !== exp8[2]) begin
         bad++; $display("FAIL wrap_hold: got %h exp %h", snap8, exp8[2]);
      end
      #2 rst8_n = 0;
      #1;
      total++;
      if (snap8 !== {8'hF8, 8'h0, 8'h0, 32'h0, 1'b0}) begin
         bad++; $display("FAIL async_reset: got %h exp %h", snap8, {8'hF8, 8'h0, 8'h0, 32'h0, 1'b0});
      end
      #1 rst8_n = 1; hold8 = 0;
      tick();
      total++;
      if (snap8 !== {8'hFC, 8'hF8, 8'hFC, 32'hA5A5_00F8, 1'b1}) begin
         bad++; $display("FAIL pend_discard: got %h exp %h", snap8, {8'hFC, 8'hF8, 8'hFC, 32'hA5A5_00F8, 1'b1});
      end
   endtask

   initial begin
      test_reset();
      test_seq_fetch();
      test_stall();
      test_branch_beats_stall();
      test_hold_redirect();
      test_flush();
      test_wrap_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
